// File: rtl/spi_slave.sv
// SPI mode-0 slave front end: oversamples SCLK/CS_N/MOSI in the i_clk domain,
// deserialises MOSI MSB-first into words and serialises the controller's tx word onto MISO.
//
// state | meaning
// IDLE  | no frame selected; SCLK activity ignored
// SHIFT | frame selected; MOSI sampled on SCLK rise, MISO advanced on SCLK fall
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    input  logic [DATA_WIDTH-1:0] i_spi_data_tx,
    output logic [DATA_WIDTH-1:0] o_spi_data_rx,
    output logic                  o_spi_ready,
    output logic                  o_spi_busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_cs_hist;

    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-2:0] r_rx_shift;
    logic [DATA_WIDTH-2:0] r_tx_shift;
    logic                  r_word_done;
    logic                  r_miso;
    logic                  r_miso_oe;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_data_rx;
    logic                  r_ready;

    logic                  w_sclk_s;
    logic                  w_cs_s;
    logic                  w_mosi_s;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic [DATA_WIDTH-1:0] w_rx_word;

    // CS sync resets low so a frame still selected at reset release never
    // produces a cs_fall; the slave waits for a fresh deassert/assert.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_hist <= w_sclk_s;
            r_cs_hist   <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;
    assign w_cs_fall   = ~w_cs_s & r_cs_hist;
    assign w_cs_rise   = w_cs_s & ~r_cs_hist;
    assign w_rx_word   = {r_rx_shift, w_mosi_s};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_word_done <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_busy      <= 1'b0;
            r_data_rx   <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (r_state == IDLE) begin
                if (w_cs_fall) begin
                    r_bit_cnt   <= '0;
                    r_tx_shift  <= i_spi_data_tx[DATA_WIDTH-2:0];
                    r_miso      <= i_spi_data_tx[DATA_WIDTH-1];
                    r_miso_oe   <= 1'b1;
                    r_busy      <= 1'b1;
                    r_word_done <= 1'b0;
                end
            end else if (w_cs_rise) begin
                r_bit_cnt   <= '0;
                r_miso      <= 1'b0;
                r_miso_oe   <= 1'b0;
                r_busy      <= 1'b0;
                r_word_done <= 1'b0;
            end else begin
                if (w_sclk_rise) begin
                    r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
                    if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt   <= '0;
                        r_data_rx   <= w_rx_word;
                        r_ready     <= 1'b1;
                        r_word_done <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                // Falling edge after a completed word loads the next slot's tx word.
                if (w_sclk_fall) begin
                    if (r_bit_cnt == '0) begin
                        if (r_word_done) begin
                            r_tx_shift <= i_spi_data_tx[DATA_WIDTH-2:0];
                            r_miso     <= i_spi_data_tx[DATA_WIDTH-1];
                        end
                    end else begin
                        r_miso     <= r_tx_shift[DATA_WIDTH-2];
                        r_tx_shift <= r_tx_shift << 1;
                    end
                end
            end
        end
    end

    assign o_miso        = r_miso;
    assign o_miso_oe     = r_miso_oe;
    assign o_spi_data_rx = r_data_rx;
    assign o_spi_ready   = r_ready;
    assign o_spi_busy    = r_busy;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: an SPI master model drives frames, a
// scoreboard queue of expected rx words is popped on every ready pulse.
module tb_spi_slave;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       cs_n  = 1'b1;
    logic       mosi  = 1'b0;
    logic [7:0] tx    = 8'h00;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx;
    logic       ready;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ready = 0;

    logic [7:0] q_rx_exp[$];
    logic [7:0] q_tx_next[$];

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) u_dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_sclk        (sclk),
        .i_cs_n        (cs_n),
        .i_mosi        (mosi),
        .o_miso        (miso),
        .o_miso_oe     (miso_oe),
        .i_spi_data_tx (tx),
        .o_spi_data_rx (rx),
        .o_spi_ready   (ready),
        .o_spi_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ready monitor: pops the scoreboard, checks pulse width, stages the next
    // tx word two cycles after the pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (ready === 1'b1) begin
                n_ready++;
                if (q_rx_exp.size() == 0)
                    check_val("rdy_unexpected", 32'(rx), 32'hFFFF_FFFF);
                else
                    check_val("rx_data", 32'(rx), 32'(q_rx_exp.pop_front()));
                @(negedge clk);
                check_val("rdy_width", 32'(ready), 32'h0);
                if (q_tx_next.size() > 0) begin
                    @(negedge clk);
                    tx = q_tx_next.pop_front();
                end
            end
        end
    end

    task automatic spi_bit(input logic b, input int ph, output logic m);
        mosi = b;
        repeat (ph) @(negedge clk);
        m    = miso;
        sclk = 1'b1;
        repeat (ph) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] w[16], input logic [7:0] t[16],
                             input int n, input int ph, input int gap);
        logic [7:0] m;
        logic       b;
        tx = t[0];
        for (int k = 1; k < n; k++) q_tx_next.push_back(t[k]);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (ph) @(negedge clk);
        check_val("busy_in_frame", 32'(busy), 32'h1);
        check_val("oe_in_frame", 32'(miso_oe), 32'h1);
        for (int k = 0; k < n; k++) begin
            q_rx_exp.push_back(w[k]);
            for (int i = 7; i >= 0; i--) begin
                spi_bit(w[k][i], ph, b);
                m[i] = b;
            end
            check_val("miso_word", 32'(m), 32'(t[k]));
        end
        repeat (ph) @(negedge clk);
        cs_n = 1'b1;
        repeat (gap) @(negedge clk);
        check_val("busy_after", 32'(busy), 32'h0);
        check_val("oe_after", 32'(miso_oe), 32'h0);
        check_val("miso_after", 32'(miso), 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w[16];
        logic [7:0] t[16];
        logic [7:0] v;
        logic       b;
        int         base;

        for (int i = 0; i < 16; i++) begin
            w[i] = 8'h00;
            t[i] = 8'h00;
        end

        repeat (3) @(negedge clk);
        check_val("rst_miso", 32'(miso), 32'h0);
        check_val("rst_oe", 32'(miso_oe), 32'h0);
        check_val("rst_rx", 32'(rx), 32'h0);
        check_val("rst_ready", 32'(ready), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Abort after 5 bits of 0xF0
        tx   = 8'hA5;
        v    = 8'hF0;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 7; i >= 3; i--) spi_bit(v[i], 6, b);
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check_val("abort_rx_hold", 32'(rx), 32'h0);
        check_val("abort_oe", 32'(miso_oe), 32'h0);
        check_val("abort_busy", 32'(busy), 32'h0);
        check_val("abort_no_ready", 32'(n_ready), 32'h0);

        w[0] = 8'h3C; t[0] = 8'hA5;
        spi_frame(w, t, 1, 6, 8);
        check_val("after_abort_ready", 32'(n_ready), 32'h1);

        base = n_ready;
        w[0] = 8'h85; t[0] = 8'hAA;
        spi_frame(w, t, 1, 7, 8);
        check_val("single_ready_cnt", 32'(n_ready - base), 32'h1);

        base = n_ready;
        w[0] = 8'h03; w[1] = 8'h00; t[0] = 8'hA5; t[1] = 8'h5C;
        spi_frame(w, t, 2, 6, 8);
        check_val("two_word_ready_cnt", 32'(n_ready - base), 32'h2);

        base = n_ready;
        w[0] = 8'h12; t[0] = 8'h21;
        spi_frame(w, t, 1, 6, 3);
        w[0] = 8'h34; t[0] = 8'h43;
        spi_frame(w, t, 1, 6, 8);
        check_val("b2b_ready_cnt", 32'(n_ready - base), 32'h2);
        check_val("b2b_last_rx", 32'(rx), 32'h34);

        // Async reset at bit 3 of a word; the live frame must then be ignored
        base = n_ready;
        tx   = 8'h77;
        v    = 8'h96;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 7; i >= 5; i--) spi_bit(v[i], 6, b);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_miso", 32'(miso), 32'h0);
        check_val("mid_rst_oe", 32'(miso_oe), 32'h0);
        check_val("mid_rst_rx", 32'(rx), 32'h0);
        check_val("mid_rst_ready", 32'(ready), 32'h0);
        check_val("mid_rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 4; i >= 0; i--) spi_bit(v[i], 6, b);
        for (int i = 0; i < 8; i++) spi_bit(1'b1, 6, b);
        check_val("post_rst_busy", 32'(busy), 32'h0);
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check_val("post_rst_no_ready", 32'(n_ready - base), 32'h0);
        w[0] = 8'h5A; t[0] = 8'h66;
        spi_frame(w, t, 1, 6, 8);
        check_val("post_rst_ready", 32'(n_ready - base), 32'h1);

        // 16-word burst at minimum SCLK phase
        base = n_ready;
        for (int i = 0; i < 16; i++) begin
            w[i] = 8'(i);
            t[i] = 8'hC0 ^ 8'(i * 5);
        end
        spi_frame(w, t, 16, 6, 8);
        check_val("burst_ready_cnt", 32'(n_ready - base), 32'd16);
        check_val("burst_last_rx", 32'(rx), 32'h0F);

        repeat (10) @(negedge clk);
        check_val("rx_queue_empty", 32'(q_rx_exp.size()), 32'h0);
        check_val("tx_queue_empty", 32'(q_tx_next.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
